// File: rtl/w5300_bus_driver_pkg.sv
// Shared constants, state encoding and load-value helper for the W5300 direct-mode bus driver.
package w5300_pkg;

    localparam int CADDR_W  = 12;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 10;
    localparam int STB_BIT  = 11;
    localparam int OP_BIT   = 10;
    localparam int ADDR_MSB = 9;

    localparam logic ADDR_S_VALID   = 1'b0;
    localparam logic ADDR_S_INVALID = 1'b1;
    localparam logic ADDR_OP_RD     = 1'b1;
    localparam logic ADDR_OP_WR     = 1'b0;

    localparam int SETUP_MIN   = 1;
    localparam int RECOVER_MIN = 2;

    typedef enum logic [3:0] {
        RST_HOLD, PLL_WAIT, READY, IDLE, SETUP, STROBE, HOLD, DONE, RECOVER
    } bus_state_e;

    // A phase lasting n cycles loads n-1: the timer reaches zero on the phase's last cycle.
    function automatic logic [31:0] load_val(input int n, input int min_n);
        int m;
        m = (n < min_n) ? min_n : n;
        return 32'(m - 1);
    endfunction

endpackage

// File: rtl/w5300_bus_driver_if.sv
// Command channel between the UDP config/comm controller and the bus driver.
interface w5300_bus_driver_if;
    import w5300_pkg::*;

    logic [CADDR_W-1:0] caddr;
    logic [DATA_W-1:0]  wr_data;
    logic               op_status;
    logic [DATA_W-1:0]  rd_data;

    modport master (output caddr, output wr_data, input op_status, input rd_data);
    modport slave  (input caddr, input wr_data, output op_status, output rd_data);
endinterface

// File: rtl/w5300_bus_driver_timer.sv
// Loadable 32-bit down-counter that saturates at zero; shared by power-up delays and bus phases.
module w5300_bus_timer #(
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    output logic        zero_o
);
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != 32'd0)
            cnt_d = cnt_q - 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= RST_VAL;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 32'd0);
endmodule

// File: rtl/w5300_bus_driver.sv
// W5300 power-up sequencer plus one timed 16-bit direct-mode read/write cycle per command.
module w5300_bus_driver
    import w5300_pkg::*;
#(
    parameter int CLK_FREQ       = 100,
    parameter int RESET_US       = 10,
    parameter int PLL_WAIT_US    = 10000,
    parameter int SETUP_CYCLES   = 1,
    parameter int RD_CYCLES      = 7,
    parameter int WR_CYCLES      = 6,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    w5300_bus_driver_if.slave   cmd,
    output logic                w5300_rst_n,
    output logic                cs_n,
    output logic                rd_n,
    output logic                wr_n,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_oe,
    input  logic [DATA_W-1:0]   data_in
);
    localparam logic [31:0] RST_LD   = load_val(RESET_US * CLK_FREQ, 1);
    localparam logic [31:0] PLL_LD   = load_val(PLL_WAIT_US * CLK_FREQ, 1);
    localparam logic [31:0] SETUP_LD = load_val(SETUP_CYCLES, SETUP_MIN);
    localparam logic [31:0] RD_LD    = load_val(RD_CYCLES, 1);
    localparam logic [31:0] WR_LD    = load_val(WR_CYCLES, 1);
    localparam logic [31:0] REC_LD   = load_val(RECOVER_CYCLES, RECOVER_MIN);

    bus_state_e          state_q, state_d;
    logic                op_rd_q, op_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                tmr_load, tmr_zero;
    logic [31:0]         tmr_val;
    logic                on_bus;

    w5300_bus_timer #(.RST_VAL(RST_LD)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_HOLD;
            op_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_rd_q <= op_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_rd_d  = op_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tmr_load = 1'b0;
        tmr_val  = 32'd0;
        unique case (state_q)
            RST_HOLD: if (tmr_zero) begin
                state_d  = PLL_WAIT;
                tmr_load = 1'b1;
                tmr_val  = PLL_LD;
            end
            PLL_WAIT: if (tmr_zero) state_d = READY;
            READY:    state_d = IDLE;
            IDLE: if (cmd.caddr[STB_BIT] == ADDR_S_VALID) begin
                // Command is captured here; later caddr/wr_data changes cannot disturb the cycle.
                op_rd_d  = (cmd.caddr[OP_BIT] == ADDR_OP_RD);
                addr_d   = cmd.caddr[ADDR_MSB:0];
                wdata_d  = cmd.wr_data;
                state_d  = SETUP;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            SETUP: if (tmr_zero) begin
                state_d  = STROBE;
                tmr_load = 1'b1;
                tmr_val  = op_rd_q ? RD_LD : WR_LD;
            end
            STROBE: if (tmr_zero) begin
                state_d = HOLD;
                if (op_rd_q) rdata_d = data_in;
            end
            HOLD: state_d = DONE;
            DONE: begin
                state_d  = RECOVER;
                tmr_load = 1'b1;
                tmr_val  = REC_LD;
            end
            RECOVER: if (tmr_zero) state_d = IDLE;
            default: state_d = RST_HOLD;
        endcase
    end

    // Strobes decode straight from state so an async reset releases them without waiting for a clock.
    assign on_bus        = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign w5300_rst_n   = (state_q != RST_HOLD);
    assign cs_n          = !on_bus;
    assign rd_n          = !((state_q == STROBE) && op_rd_q);
    assign wr_n          = !((state_q == STROBE) && !op_rd_q);
    assign data_oe       = on_bus && !op_rd_q;
    assign addr          = addr_q;
    assign data_out      = wdata_q;
    assign cmd.op_status = (state_q == READY) || (state_q == DONE);
    assign cmd.rd_data   = rdata_q;
endmodule

// File: tb/tb_w5300_bus_driver.sv
// Randomized bench for w5300_bus_driver against a cycle-offset timing model of the bus protocol.
module tb_w5300_bus_driver;
    localparam int CLK_FREQ    = 100;
    localparam int RESET_US    = 1;
    localparam int PLL_WAIT_US = 2;
    localparam int S   = 1;
    localparam int RD  = 7;
    localparam int WR  = 6;
    localparam int REC = 2;
    localparam int RST_N = RESET_US * CLK_FREQ;
    localparam int PLL_N = PLL_WAIT_US * CLK_FREQ;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w5300_rst_n, cs_n, rd_n, wr_n, data_oe;
    logic [9:0]  addr;
    logic [15:0] data_out, data_in;

    w5300_bus_driver_if cmd();

    w5300_bus_driver #(
        .CLK_FREQ(CLK_FREQ), .RESET_US(RESET_US), .PLL_WAIT_US(PLL_WAIT_US),
        .SETUP_CYCLES(S), .RD_CYCLES(RD), .WR_CYCLES(WR), .RECOVER_CYCLES(REC)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd),
        .w5300_rst_n(w5300_rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n;                 // interval index since reset release
    int acc = -1;          // interval in which the current command was accepted
    int idle_from;         // first interval in which a new command may be accepted
    logic        acc_rd;
    logic [9:0]  acc_addr;
    logic [15:0] acc_data, pend_rd, exp_rd;
    logic        prev_wr = 1'b1, prev_cs = 1'b1;
    int wr_falls = 0, cs_falls = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_cycle();
        logic e_rstn, e_cs, e_rd, e_wr, e_oe, e_op;
        int o, len;
        e_rstn = (n >= RST_N);
        e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0;
        e_op = (n == RST_N + PLL_N);
        if (acc >= 0) begin
            o   = n - acc;
            len = acc_rd ? RD : WR;
            if (o >= 1 && o <= S + len + 1) begin
                e_cs = 1'b0;
                e_oe = !acc_rd;
                chk("addr", 32'(addr), 32'(acc_addr));
                if (!acc_rd) chk("data_out", 32'(data_out), 32'(acc_data));
            end
            if (o >= S + 1 && o <= S + len) begin
                if (acc_rd) e_rd = 1'b0;
                else        e_wr = 1'b0;
            end
            if (o == S + len + 2) e_op = 1'b1;
            if (o == S + len + 1 && acc_rd) exp_rd = pend_rd;
        end
        chk("pins", 32'({w5300_rst_n, cs_n, rd_n, wr_n, data_oe, cmd.op_status}),
                    32'({e_rstn, e_cs, e_rd, e_wr, e_oe, e_op}));
        chk("rd_data", 32'(cmd.rd_data), 32'(exp_rd));
        if (prev_wr && !wr_n) wr_falls++;
        if (prev_cs && !cs_n) cs_falls++;
        prev_wr = wr_n;
        prev_cs = cs_n;
    endtask

    task automatic apply(input logic [11:0] ca, input logic [15:0] wd);
        cmd.caddr   = ca;
        cmd.wr_data = wd;
        data_in     = 16'($urandom);
        if (acc >= 0 && acc_rd && (n - acc) == S + RD) pend_rd = data_in;
        if (n >= idle_from && ca[11] == 1'b0) begin
            acc       = n;
            acc_rd    = ca[10];
            acc_addr  = ca[9:0];
            acc_data  = wd;
            idle_from = n + S + (ca[10] ? RD : WR) + 3 + REC;
        end
    endtask

    task automatic cycle(input logic [11:0] ca, input logic [15:0] wd);
        @(posedge clk); #1;
        n++;
        check_cycle();
        apply(ca, wd);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) cycle(12'hFFF, 16'h0000);
    endtask

    // Power-up with a valid command (0x208) driven the whole time; it must be ignored until IDLE.
    task automatic do_reset();
        rst = 1'b1;
        cmd.caddr = 12'hFFF; cmd.wr_data = 16'h0; data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0; acc = -1; idle_from = RST_N + PLL_N + 1; exp_rd = 16'h0;
        prev_wr = 1'b1; prev_cs = 1'b1;
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        check_cycle();
        apply(12'h208, 16'h5A5A);
        while (n < RST_N + PLL_N) cycle(12'h208, 16'h5A5A);
        idle_cycles(2);
    endtask

    initial begin
        int base;
        cmd.caddr = 12'hFFF; cmd.wr_data = 16'h0; data_in = 16'h0;
        do_reset();

        cycle(12'h214, 16'hC0A8);
        idle_cycles(14);
        cycle(12'h608, 16'h0000);
        idle_cycles(14);

        // Controller-style: first write held one cycle past op_status, then re-issued with new data.
        base = wr_falls;
        for (int i = 0; i < 11; i++) cycle(12'h22E, 16'h1111);
        cycle(12'h22E, 16'h2222);
        cycle(12'h22E, 16'h2222);
        idle_cycles(14);
        chk("two_wr_pulses", 32'(wr_falls - base), 32'd2);

        // caddr dropped to invalid mid-strobe: cycle completes once, nothing re-issued.
        base = cs_falls;
        cycle(12'h155, 16'hBEEF);
        cycle(12'h155, 16'hBEEF);
        cycle(12'h155, 16'hBEEF);
        idle_cycles(14);
        chk("one_cs_pulse", 32'(cs_falls - base), 32'd1);

        for (int i = 0; i < 400; i++) cycle(12'($urandom), 16'($urandom));
        idle_cycles(14);

        // Reset asserted during a write's strobe phase.
        cycle(12'h214, 16'hA5A5);
        idle_cycles(3);
        #2 rst = 1'b1;
        #1 chk("async_rst_pins", 32'({w5300_rst_n, cs_n, wr_n, rd_n, data_oe}), 32'b01110);
        do_reset();
        cycle(12'h214, 16'h7E7E);
        idle_cycles(14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
